gf180mcu_fd_sc_mcu9t5v0__fillcap_seq: RTL and testbench

- Parametrised sequencer for a bank of NCH switchable fill-capacitor segments.
- Successor to the fixed, always-on fillcap cells: segments are enabled or disabled one at a time, paced by a programmable step interval. This limits inrush and discharge transients on VDD/VSS.
- Sits next to the power-gated decap array in the standard-cell fill region. A power-management controller drives it through a REQ/ACK handshake.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__fillcap_seq.sv | 129 ++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__fillcap_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__fillcap_seq.sv
// gf180mcu_fd_sc_mcu9t5v0__fillcap_seq
//
// Sequencer for a bank of NCH switchable fill-capacitor segments. Segments
// are switched on or off one at a time, with STEP_CYC clocks between
// changes, so that VDD/VSS see small current steps instead of one large
// transient. A power-management controller drives it through REQ/ACK.
//
// Ports:
//   CLK   clock
//   RST   synchronous active-high reset
//   VDD   supply pin, no logic function
//   VSS   ground pin, no logic function
//   REQ   request strobe; TGT is sampled when the request is accepted
//   TGT   requested number of enabled segments (values above NCH are clamped)
//   ACK   one-cycle pulse when LVL reaches the latched target
//   BUSY  high while ramping
//   LVL   current number of enabled segments
//   EN    segment enables, thermometer code of LVL (EN[i]=1 iff i<LVL)
//
// Build option:
//   GF180MCU_FILLCAP_SEQ_RETARGET_EN  when defined, a REQ during a ramp is
//   accepted and retargets it. Without it, REQ is ignored while BUSY=1.
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | no ramp in progress, BUSY=0, requests accepted
// UP    | LVL incrementing toward the latched target
// DN    | LVL decrementing toward the latched target

module gf180mcu_fd_sc_mcu9t5v0__fillcap_seq #(
  parameter int NCH      = 8,
  parameter int STEP_CYC = 4,
  parameter int LW       = $clog2(NCH + 1)
) (
  input  logic           CLK,
  input  logic           RST,
  inout  wire            VDD,
  inout  wire            VSS,
  input  logic           REQ,
  input  logic [LW-1:0]  TGT,
  output logic           ACK,
  output logic           BUSY,
  output logic [LW-1:0]  LVL,
  output logic [NCH-1:0] EN
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DN   = 2'd2;

  localparam int TW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [TW-1:0] TMAX  = TW'(STEP_CYC - 1);
  localparam logic [LW-1:0] NCH_L = LW'(NCH);

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [LW-1:0] tgt_q;

  logic [LW-1:0] tgt_clamp;
  logic [LW-1:0] lvl_step;
  logic          step_due;
  logic          accept;

  // Supply pins only pass through; this keeps them referenced.
  wire unused_supply = VDD ^ VSS;

  function automatic logic [NCH-1:0] therm(input logic [LW-1:0] n);
    logic [NCH-1:0] t;
    for (int i = 0; i < NCH; i++) begin
      t[i] = (i < int'(n));
    end
    return t;
  endfunction

  assign tgt_clamp = (TGT > NCH_L) ? NCH_L : TGT;
  assign lvl_step  = (state == UP) ? LVL + LW'(1) : LVL - LW'(1);
  assign step_due  = (timer == TMAX);

`ifdef GF180MCU_FILLCAP_SEQ_RETARGET_EN
  // Retarget: a request mid-ramp relatches the target and restarts the timer.
  assign accept = REQ;
`else
  assign accept = REQ && (state == IDLE);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      timer <= '0;
      tgt_q <= '0;
      LVL   <= '0;
      EN    <= '0;
      BUSY  <= 1'b0;
      ACK   <= 1'b0;
    end else begin
      ACK <= 1'b0;
      if (accept) begin
        tgt_q <= tgt_clamp;
        timer <= '0;
        if (tgt_clamp > LVL) begin
          state <= UP;
          BUSY  <= 1'b1;
        end else if (tgt_clamp < LVL) begin
          state <= DN;
          BUSY  <= 1'b1;
        end else begin
          // Already at target: acknowledge without touching EN.
          state <= IDLE;
          BUSY  <= 1'b0;
          ACK   <= 1'b1;
        end
      end else if (state != IDLE) begin
        if (step_due) begin
          timer <= '0;
          LVL   <= lvl_step;
          EN    <= therm(lvl_step);
          if (lvl_step == tgt_q) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            ACK   <= 1'b1;
          end
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__fillcap_seq.sv
// Directed bench for gf180mcu_fd_sc_mcu9t5v0__fillcap_seq (NCH=8, STEP_CYC=4).
// Expected observations are queued with the cycle at which they are due and
// checked as the cycle counter reaches them.

module tb_gf180mcu_fd_sc_mcu9t5v0__fillcap_seq;

  localparam int NCH  = 8;
  localparam int STEP = 4;
  localparam int LW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [LW-1:0] tgt;
  logic          ack;
  logic          busy;
  logic [LW-1:0] lvl;
  logic [NCH-1:0] en;
  wire           vdd = 1'b1;
  wire           vss = 1'b0;

  gf180mcu_fd_sc_mcu9t5v0__fillcap_seq #(
    .NCH(NCH),
    .STEP_CYC(STEP)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .VDD (vdd),
    .VSS (vss),
    .REQ (req),
    .TGT (tgt),
    .ACK (ack),
    .BUSY(busy),
    .LVL (lvl),
    .EN  (en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             due;
    logic [NCH-1:0] en;
    logic [LW-1:0]  lvl;
    logic           busy;
    logic           ack;
    string          tag;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   acks = 0;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [NCH-1:0] tb_therm(input int l);
    return NCH'((1 << l) - 1);
  endfunction

  function automatic void push(input int due, input int l, input logic b,
                               input logic a, input string tag);
    exp_t e;
    e.due  = due;
    e.en   = tb_therm(l);
    e.lvl  = LW'(l);
    e.busy = b;
    e.ack  = a;
    e.tag  = tag;
    sbq.push_back(e);
  endfunction

  // Queue the full expected trajectory of a request accepted at edge c0.
  function automatic int push_ramp(input int c0, input int from, input int raw);
    int t;
    int n;
    int dir;
    t   = (raw > NCH) ? NCH : raw;
    n   = (t > from) ? t - from : from - t;
    dir = (t > from) ? 1 : -1;
    push(c0, from, n != 0, n == 0, "accept");
    for (int k = 1; k <= n; k++) begin
      push(c0 + STEP * k, from + dir * k, k < n, k == n, "step");
    end
    push(c0 + STEP * n + 1, t, 1'b0, 1'b0, "ack_drop");
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @cyc%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (ack === 1'b1) acks++;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk({e.tag, "_en"},   32'(en),   32'(e.en));
      chk({e.tag, "_lvl"},  32'(lvl),  32'(e.lvl));
      chk({e.tag, "_busy"}, 32'(busy), 32'(e.busy));
      chk({e.tag, "_ack"},  32'(ack),  32'(e.ack));
    end
  endtask

  task automatic drain();
    int lim;
    lim = cyc + 400;
    while (sbq.size() > 0 && cyc < lim) step();
    if (sbq.size() > 0) begin
      chk("drain_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  task automatic request(input int raw, input int from, output int fin);
    req = 1'b1;
    tgt = LW'(raw);
    fin = push_ramp(cyc + 1, from, raw);
    step();
    req = 1'b0;
  endtask

  initial begin
    int cur;
    int c0;
    int acks0;

    rst = 1'b1;
    req = 1'b0;
    tgt = '0;
    step();
    step();
    push(cyc + 1, 0, 1'b0, 1'b0, "in_reset");
    step();
    rst = 1'b0;

    // Idle after reset: nothing moves, no ACK.
    for (int i = 1; i <= 10; i++) push(cyc + i, 0, 1'b0, 1'b0, "idle");
    drain();
    chk("idle_no_ack", 32'(acks), 32'd0);

    // 0 -> 3
    request(3, 0, cur);
    drain();
    chk("up3_acks", 32'(acks), 32'd1);

    // 3 -> 15 clamped to 8
    request(15, cur, cur);
    drain();
    chk("clamp_lvl", 32'(cur), 32'd8);
    chk("clamp_acks", 32'(acks), 32'd2);

    // Same-level request, then 8 -> 6
    request(8, cur, cur);
    drain();
    chk("same_acks", 32'(acks), 32'd3);
    request(6, cur, cur);
    drain();
    chk("dn6_acks", 32'(acks), 32'd4);

    // Back to 0, then reset 6 cycles into a 0 -> 5 ramp.
    request(0, cur, cur);
    drain();
    acks0 = acks;
    c0 = cyc + 1;
    req = 1'b1;
    tgt = LW'(5);
    push(c0, 0, 1'b1, 1'b0, "rst_accept");
    push(c0 + STEP, 1, 1'b1, 1'b0, "rst_step1");
    step();
    req = 1'b0;
    while (cyc < c0 + 5) step();
    rst = 1'b1;
    push(c0 + 6, 0, 1'b0, 1'b0, "rst_mid");
    step();
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) push(cyc + i, 0, 1'b0, 1'b0, "post_rst");
    drain();
    chk("rst_no_ack", 32'(acks), 32'(acks0));
    cur = 0;

    // 0 -> 6, then 6 -> 0 with a TGT=2 request arriving at LVL=5.
    request(6, cur, cur);
    drain();
    acks0 = acks;
    c0 = cyc + 1;
    req = 1'b1;
    tgt = '0;
`ifdef GF180MCU_FILLCAP_SEQ_RETARGET_EN
    push(c0, 6, 1'b1, 1'b0, "rt_accept");
    push(c0 + STEP, 5, 1'b1, 1'b0, "rt_step1");
`else
    cur = push_ramp(c0, 6, 0);
`endif
    step();
    req = 1'b0;
    while (cyc < c0 + STEP) step();
    req = 1'b1;
    tgt = LW'(2);
`ifdef GF180MCU_FILLCAP_SEQ_RETARGET_EN
    cur = push_ramp(cyc + 1, 5, 2);
`endif
    step();
    req = 1'b0;
    drain();
`ifdef GF180MCU_FILLCAP_SEQ_RETARGET_EN
    chk("rt_final_lvl", 32'(lvl), 32'd2);
`else
    chk("rt_final_lvl", 32'(lvl), 32'd0);
`endif
    chk("rt_final_cur", 32'(lvl), 32'(cur));
    chk("rt_acks", 32'(acks), 32'(acks0 + 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
